// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception controller: Status/Cause/EPC, irq synchronisers, trap latching, handler vectoring.
// Optional CP0_VECTORED_EN: per-interrupt vector offset indexed by the highest pending IP[15:10] bit.
module cp0_exc_ctrl #(
  parameter int          NIRQ  = 6,
  parameter int          NTRAP = 2,
  parameter logic [31:0] BASE  = 32'h8000_0180
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [4:0]       addr,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  input  logic [NIRQ-1:0]  irq,
  input  logic [NTRAP-1:0] trap,
  input  logic [31:0]      pc,
  input  logic             eret,
  output logic             exl,
  output logic             iv,
  output logic [4:0]       exc_code,
  output logic [31:0]      vector
);

  // state   | meaning
  // RUN     | normal execution, EXL=0, sources may be taken
  // HANDLER | inside handler, EXL=1, sources only accumulate in IP
  typedef enum logic {RUN, HANDLER} state_t;

  // IP/IM bits 15:8 are held as [7:0]; only wired sources are implemented.
  localparam logic [7:0] IMPL = 8'((((1 << NIRQ) - 1) << 2) | ((1 << NTRAP) - 1));

  state_t            state, state_n;
  logic              take;
  logic [NIRQ-1:0]   sync1, sync2;
  logic              ie;
  logic [7:0]        im, ip, ip_n, hw_set, sw_clr;
  logic              iv_q;
  logic [4:0]        code;
  logic [31:0]       epc;
  logic              wr_status, wr_cause, wr_epc;
  logic              unused_wd;

  assign wr_status = we && (addr == 5'd12);
  assign wr_cause  = we && (addr == 5'd13);
  assign wr_epc    = we && (addr == 5'd14);
  assign unused_wd = ^{wd[31:24], wd[22:16], wd[7:1]};

  always_comb begin
    hw_set = '0;
    for (int i = 0; i < NIRQ; i++) hw_set[2+i] = sync2[i];
    for (int t = 0; t < NTRAP; t++) hw_set[t] = trap[t];
    hw_set = hw_set & im;
    sw_clr = wr_cause ? ~wd[15:8] : 8'h00;
    // Hardware set wins over a software clear of the same bit.
    ip_n   = ((ip & ~sw_clr) | hw_set) & im & IMPL;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    case (state)
      RUN: begin
        if (ie && (|ip)) begin
          take    = 1'b1;
          state_n = HANDLER;
        end
      end
      HANDLER: begin
        if (eret) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

`ifdef CP0_VECTORED_EN
  logic [2:0] idx, hi_idx;

  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < NIRQ; i++) if (ip[2+i]) hi_idx = 3'(i);
  end

  always_ff @(posedge clk) begin
    if (!rst)      idx <= '0;
    else if (take) idx <= hi_idx;
  end

  always_comb begin
    if (iv_q && (code != 5'd13)) vector = BASE + 32'h80 + ({29'd0, idx} << 5);
    else                         vector = BASE;
  end
`else
  always_comb begin
    if (iv_q && (code != 5'd13)) vector = BASE + 32'h80;
    else                         vector = BASE;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      ie    <= 1'b0;
      im    <= '0;
      ip    <= '0;
      iv_q  <= 1'b0;
      code  <= '0;
      epc   <= '0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      ip    <= ip_n;
      if (wr_status) begin
        ie <= wd[0];
        im <= wd[15:8] & IMPL;
      end
      if (wr_cause) iv_q <= wd[23];
      // Entry capture takes priority over a software EPC write on the same edge.
      if (take) begin
        epc  <= pc;
        code <= (|ip[7:2]) ? 5'd0 : 5'd13;
      end else if (wr_epc) begin
        epc <= wd;
      end
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      5'd12:   rd = {16'd0, im, 6'd0, exl, ie};
      5'd13:   rd = {8'd0, iv_q, 7'd0, ip, 1'b0, code, 2'b00};
      5'd14:   rd = epc;
      default: rd = '0;
    endcase
  end

  assign exl      = (state == HANDLER);
  assign iv       = iv_q;
  assign exc_code = code;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed, table-driven bench for cp0_exc_ctrl; each row is one clock of stimulus with post-edge expectations.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] B    = 32'h8000_0180;
  localparam logic [31:0] B2   = 32'h8000_0200;
  localparam logic [31:0] V220 = 32'h8000_0220;
  localparam logic [31:0] V280 = 32'h8000_0280;
  localparam logic [31:0] P1 = 32'h0040_0010, P2 = 32'h0040_0020, P4 = 32'h0040_0040;
  localparam logic [31:0] P3 = 32'h0040_0030, P5 = 32'h0040_0050, P6 = 32'h0040_0060;

  logic        clk, rst, we, eret;
  logic [4:0]  addr;
  logic [31:0] wd, pc, rd, vector;
  logic [5:0]  irq;
  logic [1:0]  trap;
  logic        exl, iv;
  logic [4:0]  exc_code;

  int errors = 0;
  int checks = 0;

  cp0_exc_ctrl #(.NIRQ(6), .NTRAP(2), .BASE(32'h8000_0180)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .irq(irq), .trap(trap), .pc(pc), .eret(eret),
    .exl(exl), .iv(iv), .exc_code(exc_code), .vector(vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [5:0]  irq;
    logic [1:0]  trap;
    logic [31:0] pc;
    logic        eret;
    logic [31:0] exp_rd;
    logic        exp_exl;
    logic [31:0] vec_nv, vec_v;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [5:0] iq, input logic [1:0] tp, input logic [31:0] p, input logic er,
                     input logic [31:0] xrd, input logic xexl, input logic [31:0] vnv, input logic [31:0] vv);
    vec_t v;
    v = '{r, w, a, d, iq, tp, p, er, xrd, xexl, vnv, vv};
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; we = v.we; addr = v.addr; wd = v.wd;
    irq = v.irq; trap = v.trap; pc = v.pc; eret = v.eret;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; addr = '0; wd = '0; irq = '0; trap = '0; pc = '0; eret = 1'b0;

    //   rst we addr wd            irq   trap pc  eret  exp_rd        exl vec_nv vec_v
    add(0, 0, 12, 0,             0,    0, 0,  0,    0,            0, B,  B);
    add(0, 0, 13, 0,             0,    0, 0,  0,    0,            0, B,  B);
    add(0, 0, 14, 0,             0,    0, 0,  0,    0,            0, B,  B);
    add(1, 1, 12, 32'h401,       0,    0, 0,  0,    32'h401,      0, B,  B);
    add(1, 0, 13, 0,             1,    0, P1, 0,    0,            0, B,  B);
    add(1, 0, 13, 0,             0,    0, P1, 0,    0,            0, B,  B);
    add(1, 0, 13, 0,             0,    0, P1, 0,    32'h400,      0, B,  B);
    add(1, 0, 13, 0,             0,    0, P1, 0,    32'h400,      1, B,  B);
    add(1, 0, 14, 0,             0,    0, P1, 0,    P1,           1, B,  B);
    add(1, 1, 13, 0,             0,    0, 0,  1,    0,            0, B,  B);
    add(1, 0, 12, 0,             0,    0, 0,  0,    32'h401,      0, B,  B);
    add(1, 1, 12, 32'h101,       0,    0, 0,  0,    32'h101,      0, B,  B);
    add(1, 1, 13, 32'h0080_0000, 0,    0, 0,  0,    32'h0080_0000,0, B2, B2);
    add(1, 0, 13, 0,             0,    1, P2, 0,    32'h0080_0100,0, B2, B2);
    add(1, 0, 13, 0,             0,    0, P2, 0,    32'h0080_0134,1, B,  B);
    add(1, 0, 14, 0,             0,    0, P2, 0,    P2,           1, B,  B);
    add(1, 1, 13, 32'h0080_0000, 0,    0, P2, 0,    32'h0080_0034,1, B,  B);
    add(1, 1, 12, 32'h801,       0,    0, P2, 0,    32'h803,      1, B,  B);
    add(1, 0, 14, 0,             2,    0, P3, 0,    P2,           1, B,  B);
    add(1, 0, 14, 0,             2,    0, P3, 0,    P2,           1, B,  B);
    add(1, 0, 14, 0,             2,    0, P3, 0,    P2,           1, B,  B);
    add(1, 0, 14, 0,             2,    0, P3, 0,    P2,           1, B,  B);
    add(1, 0, 13, 0,             2,    0, P4, 1,    32'h0080_0834,0, B,  B);
    add(1, 0, 14, 0,             2,    0, P4, 0,    P4,           1, B2, V220);
    add(1, 0, 13, 0,             0,    0, P4, 0,    32'h0080_0800,1, B2, V220);
    add(1, 0, 13, 0,             0,    0, P4, 0,    32'h0080_0800,1, B2, V220);
    add(1, 1, 13, 32'h0080_0000, 0,    0, P4, 1,    32'h0080_0000,0, B2, V220);
    add(1, 1, 12, 32'h5400,      0,    0, P4, 0,    32'h5400,     0, B2, V220);
    add(1, 0, 13, 0,             6'h14,0, P4, 0,    32'h0080_0000,0, B2, V220);
    add(1, 0, 13, 0,             6'h14,0, P4, 0,    32'h0080_0000,0, B2, V220);
    add(1, 0, 13, 0,             6'h14,0, P4, 0,    32'h0080_5000,0, B2, V220);
    add(1, 1, 12, 32'h5401,      0,    0, P5, 0,    32'h5401,     0, B2, V220);
    add(1, 0, 14, 0,             0,    0, P5, 0,    P5,           1, B2, V280);
    add(1, 0, 13, 0,             0,    0, P5, 0,    32'h0080_5000,1, B2, V280);
    add(1, 0, 13, 0,             1,    0, P5, 0,    32'h0080_5000,1, B2, V280);
    add(1, 0, 13, 0,             1,    0, P5, 0,    32'h0080_5000,1, B2, V280);
    add(1, 1, 13, 32'h0080_0000, 1,    0, P5, 0,    32'h0080_0400,1, B2, V280);
    add(0, 0, 13, 0,             0,    0, P5, 0,    0,            0, B,  B);
    add(0, 0, 12, 0,             0,    0, P5, 0,    0,            0, B,  B);
    add(1, 1, 12, 32'h101,       0,    0, P5, 0,    32'h101,      0, B,  B);
    add(1, 0, 14, 0,             0,    1, P5, 0,    0,            0, B,  B);
    add(1, 1, 14, 32'hDEAD_BEEF, 0,    0, P6, 0,    P6,           1, B,  B);
    add(1, 0, 5,  0,             0,    0, P6, 0,    0,            1, B,  B);
    add(1, 1, 12, 32'hFFFF_FFFF, 0,    0, P6, 0,    32'hFF03,     1, B,  B);
    add(1, 1, 14, 32'h1234_5678, 0,    0, P6, 0,    32'h1234_5678,1, B,  B);
    add(1, 0, 13, 0,             0,    0, P6, 0,    32'h134,      1, B,  B);

    foreach (tv[i]) begin
      drive(tv[i]);
      chk($sformatf("row%0d_rd", i), rd, tv[i].exp_rd);
      chk($sformatf("row%0d_exl", i), {31'd0, exl}, {31'd0, tv[i].exp_exl});
`ifdef CP0_VECTORED_EN
      chk($sformatf("row%0d_vector", i), vector, tv[i].vec_v);
`else
      chk($sformatf("row%0d_vector", i), vector, tv[i].vec_nv);
`endif
    end

    // eret with IP8 still pending: one cycle of exl=0, then re-entry capturing the new pc
    rst = 1'b1; we = 1'b0; addr = 5'd13; wd = '0; irq = '0; trap = '0; pc = P6; eret = 1'b1;
    @(posedge clk); #1;
    chk("eret_exl_low", {31'd0, exl}, 32'd0);
    chk("eret_exc_code", {27'd0, exc_code}, 32'd13);
    chk("eret_iv", {31'd0, iv}, 32'd0);
    eret = 1'b0; addr = 5'd14; pc = 32'h0040_0070;
    @(posedge clk); #1;
    chk("reentry_exl", {31'd0, exl}, 32'd1);
    chk("reentry_epc", rd, 32'h0040_0070);

    // software IV write shows on the port; reset then clears it
    we = 1'b1; addr = 5'd13; wd = 32'h0080_0000;
    @(posedge clk); #1;
    chk("iv_set", {31'd0, iv}, 32'd1);
    we = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_iv", {31'd0, iv}, 32'd0);
    chk("rst_exc_code", {27'd0, exc_code}, 32'd0);
    chk("rst_vector", vector, B);
    chk("rst_exl", {31'd0, exl}, 32'd0);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
